// File: rtl/instruction_decode_stage.sv
// MIPS R/I/J instruction decoder with a BUF_DEPTH-entry decoded-record FIFO.
// Optional illegal-opcode trap and counter enabled by `define DECODE_ILLEGAL_TRAP_EN.
module instruction_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [5:0]            funct,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic [25:0]           target,
    output logic [1:0]            fmt,
    output logic [4:0]            wr_reg,
    output logic                  illegal,
    output logic [15:0]           illegal_cnt
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(BUF_DEPTH);

    function automatic logic [1:0] fmt_of(input logic [5:0] op);
        if (op == 6'h00)
            return 2'b00;
        else if (op == 6'h02 || op == 6'h03)
            return 2'b10;
        else
            return 2'b01;
    endfunction

    // Logical-immediate opcodes zero-extend; everything else, R and J included, sign-extends.
    function automatic logic [DATA_WIDTH-1:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
        logic signed [15:0] imm_s;
        imm_s = imm;
        if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F})
            return DATA_WIDTH'(imm);
        else
            return DATA_WIDTH'(imm_s);
    endfunction

    function automatic logic [4:0] wr_reg_of(input logic [5:0] op, input logic [4:0] f_rt,
                                             input logic [4:0] f_rd);
        if (op == 6'h03)
            return 5'd31;
        else if (op inside {6'h02, 6'h04, 6'h05, 6'h2B})
            return 5'd0;
        else if (op == 6'h00)
            return f_rd;
        else
            return f_rt;
    endfunction

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Stage p0: combinational decode of the incoming word
    logic [1:0]            fmt_p0;
    logic [4:0]            wr_reg_p0;
    logic [DATA_WIDTH-1:0] imm_p0;

    assign fmt_p0    = fmt_of(instr[31:26]);
    assign wr_reg_p0 = wr_reg_of(instr[31:26], instr[20:16], instr[15:11]);
    assign imm_p0    = ext_imm(instr[31:26], instr[15:0]);

    // Stage p1: decoded-record FIFO storage (data only, never reset)
    logic [31:0]           instr_p1  [BUF_DEPTH];
    logic [1:0]            fmt_p1    [BUF_DEPTH];
    logic [4:0]            wr_reg_p1 [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] imm_p1    [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            instr_p1[wr_ptr]  <= instr;
            fmt_p1[wr_ptr]    <= fmt_p0;
            wr_reg_p1[wr_ptr] <= wr_reg_p0;
            imm_p1[wr_ptr]    <= imm_p0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign opcode  = instr_p1[rd_ptr][31:26];
    assign rs      = instr_p1[rd_ptr][25:21];
    assign rt      = instr_p1[rd_ptr][20:16];
    assign rd      = instr_p1[rd_ptr][15:11];
    assign shamt   = instr_p1[rd_ptr][10:6];
    assign funct   = instr_p1[rd_ptr][5:0];
    assign target  = instr_p1[rd_ptr][25:0];
    assign fmt     = fmt_p1[rd_ptr];
    assign wr_reg  = wr_reg_p1[rd_ptr];
    assign imm_ext = imm_p1[rd_ptr];

`ifdef DECODE_ILLEGAL_TRAP_EN
    function automatic logic is_illegal(input logic [5:0] op);
        return !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B});
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic illegal_p0;
    logic illegal_p1 [BUF_DEPTH];
    logic [15:0] illegal_cnt_q;

    assign illegal_p0 = is_illegal(instr[31:26]);

    always_ff @(posedge clk) begin
        if (push)
            illegal_p1[wr_ptr] <= illegal_p0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            illegal_cnt_q <= '0;
        else if (push && illegal_p0)
            illegal_cnt_q <= sat_inc16(illegal_cnt_q);
    end

    // Storage is not cleared by reset, so gate the flag with occupancy.
    assign illegal     = out_valid && illegal_p1[rd_ptr];
    assign illegal_cnt = illegal_cnt_q;
`else
    assign illegal     = 1'b0;
    assign illegal_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: decode vectors, FIFO corners,
// reset mid-stream, and randomized traffic against a queue-based reference model.
module tb_instruction_decode_stage;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [5:0]    opcode;
    logic [4:0]    rs, rt, rd, shamt;
    logic [5:0]    funct;
    logic [DW-1:0] imm_ext;
    logic [25:0]   target;
    logic [1:0]    fmt;
    logic [4:0]    wr_reg;
    logic          illegal;
    logic [15:0]   illegal_cnt;

    instruction_decode_stage #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_ext(imm_ext), .target(target), .fmt(fmt), .wr_reg(wr_reg),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rules for the decode, stated directly from the format definitions.
    function automatic logic [1:0] ref_fmt(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        if (op == 0) return 2'd0;
        if (op == 2 || op == 3) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        if (op >= 6'h0C && op <= 6'h0F) return {16'h0000, w[15:0]};
        return {{16{w[15]}}, w[15:0]};
    endfunction

    function automatic logic [4:0] ref_wr(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        if (op == 6'h03) return 5'd31;
        if (op == 6'h02 || op == 6'h04 || op == 6'h05 || op == 6'h2B) return 5'd0;
        if (op == 6'h00) return w[15:11];
        return w[20:16];
    endfunction

    function automatic logic ref_illegal(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        logic ok;
        ok = (op == 6'h00) || (op >= 6'h02 && op <= 6'h05) || (op >= 6'h08 && op <= 6'h0F) ||
             (op == 6'h23) || (op == 6'h2B);
        return TRAP && !ok;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 15))
            0, 1: w[31:26] = 6'h00;
            2:    w[31:26] = 6'h02;
            3:    w[31:26] = 6'h03;
            4:    w[31:26] = 6'h04;
            5:    w[31:26] = 6'h05;
            6:    w[31:26] = 6'h08;
            7:    w[31:26] = 6'h0C;
            8:    w[31:26] = 6'h0D;
            9:    w[31:26] = 6'h0F;
            10:   w[31:26] = 6'h23;
            11:   w[31:26] = 6'h2B;
            12:   w[31:26] = 6'h3F;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_head(input string name, input logic [31:0] w);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_fields"}, {opcode, rs, rt, rd, shamt, funct}, w);
        chk({name, "_target"}, target, w[25:0]);
        chk({name, "_fmt"}, fmt, ref_fmt(w));
        chk({name, "_wr_reg"}, wr_reg, ref_wr(w));
        chk({name, "_imm"}, imm_ext, ref_imm(w));
        chk({name, "_illegal"}, illegal, ref_illegal(w));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [25:0] tgt;
        logic [1:0]  fmt;
        logic [4:0]  wr;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[11];
    logic [31:0] q[$];
    int          mcnt;
    logic        push, pop;

    initial begin
        vecs[0]  = '{32'h00000000, 6'h00, 5'd0, 5'd0,  5'd0,  6'h00, 26'h0000000, 2'd0, 5'd0,  32'h00000000};
        vecs[1]  = '{32'h00221820, 6'h00, 5'd1, 5'd2,  5'd3,  6'h20, 26'h0221820, 2'd0, 5'd3,  32'h00001820};
        vecs[2]  = '{32'h2085FFFF, 6'h08, 5'd4, 5'd5,  5'd31, 6'h3F, 26'h085FFFF, 2'd1, 5'd5,  32'hFFFFFFFF};
        vecs[3]  = '{32'h3485FFFF, 6'h0D, 5'd4, 5'd5,  5'd31, 6'h3F, 26'h085FFFF, 2'd1, 5'd5,  32'h0000FFFF};
        vecs[4]  = '{32'h0C100000, 6'h03, 5'd0, 5'd16, 5'd0,  6'h00, 26'h0100000, 2'd2, 5'd31, 32'h00000000};
        vecs[5]  = '{32'h08000010, 6'h02, 5'd0, 5'd0,  5'd0,  6'h10, 26'h0000010, 2'd2, 5'd0,  32'h00000010};
        vecs[6]  = '{32'hAC220004, 6'h2B, 5'd1, 5'd2,  5'd0,  6'h04, 26'h0220004, 2'd1, 5'd0,  32'h00000004};
        vecs[7]  = '{32'h1022FFFE, 6'h04, 5'd1, 5'd2,  5'd31, 6'h3E, 26'h022FFFE, 2'd1, 5'd0,  32'hFFFFFFFE};
        vecs[8]  = '{32'h30228000, 6'h0C, 5'd1, 5'd2,  5'd16, 6'h00, 26'h0228000, 2'd1, 5'd2,  32'h00008000};
        vecs[9]  = '{32'h8C22FFFC, 6'h23, 5'd1, 5'd2,  5'd31, 6'h3C, 26'h022FFFC, 2'd1, 5'd2,  32'hFFFFFFFC};
        vecs[10] = '{32'h3C011234, 6'h0F, 5'd0, 5'd1,  5'd2,  6'h34, 26'h0011234, 2'd1, 5'd1,  32'h00001234};

        do_reset();
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_illegal", illegal, 1'b0);
        chk("reset_illegal_cnt", illegal_cnt, 16'd0);

        // Single-word decode vectors: one cycle latency, then pop.
        for (int i = 0; i < 11; i++) begin
            instr    = vecs[i].instr;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk("vec_out_valid", out_valid, 1'b1);
            chk("vec_opcode", opcode, vecs[i].op);
            chk("vec_rs", rs, vecs[i].rs);
            chk("vec_rt", rt, vecs[i].rt);
            chk("vec_rd", rd, vecs[i].rd);
            chk("vec_funct", funct, vecs[i].funct);
            chk("vec_target", target, vecs[i].tgt);
            chk("vec_fmt", fmt, vecs[i].fmt);
            chk("vec_wr_reg", wr_reg, vecs[i].wr);
            chk("vec_imm_ext", imm_ext, vecs[i].imm);
            chk("vec_illegal", illegal, 1'b0);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            chk("vec_drained", out_valid, 1'b0);
        end

        // Fill to full with the consumer stalled, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00221820;
        @(posedge clk);
        @(negedge clk);
        chk("fill1_in_ready", in_ready, 1'b1);
        instr = 32'h2085FFFF;
        @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        instr = 32'h0C100000;
        @(posedge clk);
        @(negedge clk);
        chk("full_hold_in_ready", in_ready, 1'b0);
        check_head("full_hold_head", 32'h00221820);
        out_ready = 1'b1;
        chk("full_pop_no_comb_ready", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("after_pop_in_ready", in_ready, 1'b1);
        check_head("after_pop_head", 32'h2085FFFF);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("refill_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        check_head("drain_head1", 32'h2085FFFF);
        @(posedge clk);
        @(negedge clk);
        check_head("drain_head2", 32'h0C100000);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 1'b0);

        // Simultaneous push and pop keeps occupancy at one.
        in_valid = 1'b1;
        instr    = 32'h3485FFFF;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        instr     = 32'h8C22FFFC;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_head("pushpop_head", 32'h8C22FFFC);
        chk("pushpop_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("pushpop_empty", out_valid, 1'b0);

        // Two unsupported-opcode words, then asynchronous reset mid-stream.
        in_valid = 1'b1;
        instr    = 32'hFC000000;
        @(posedge clk);
        @(negedge clk);
        instr = 32'hFC00ABCD;
        @(posedge clk);
        @(negedge clk);
        chk("illegal_head", illegal, TRAP);
        chk("illegal_cnt_two", illegal_cnt, TRAP ? 16'd2 : 16'd0);
        check_head("illegal_head_rec", 32'hFC000000);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk("async_rst_illegal", illegal, 1'b0);
        chk("async_rst_illegal_cnt", illegal_cnt, 16'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // Randomized traffic against the queue model.
        q.delete();
        mcnt = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            chk("rnd_in_ready", in_ready, q.size() != DEPTH);
            chk("rnd_illegal_cnt", illegal_cnt, 16'(mcnt));
            if (q.size() != 0)
                check_head("rnd_head", q[0]);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = rand_word();
            push      = in_valid && (q.size() < DEPTH);
            pop       = out_ready && (q.size() > 0);
            @(posedge clk);
            if (pop)
                void'(q.pop_front());
            if (push) begin
                q.push_back(instr);
                if (ref_illegal(instr) && mcnt < 65535)
                    mcnt++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
